// File: rtl/tank_life_ctrl.sv
// tank_life_ctrl: tank life/explosion/respawn/invulnerability sequencer
module tank_life_ctrl #(
    parameter logic [31:0] BURST_CYCLES  = 32'h3000000,
    parameter logic [31:0] RESET_CYCLES  = 32'd16,
    parameter logic [31:0] INVULN_CYCLES = 32'd100_000_000,
    parameter int          LIVES         = 3,
    parameter int          BLINK_BIT     = 22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       new_game,
    output logic       burst,
    output logic       tank_reset,
    output logic       invuln,
    output logic       blink,
    output logic [1:0] lives,
    output logic       game_over
);
    typedef enum logic [2:0] {ALIVE, BURST, RESPAWN, INVULN, DEAD} state_t;
    localparam logic [1:0] FULL = 2'(LIVES);
    state_t      state;
    logic [31:0] counter;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ALIVE;
            counter <= '0;
            lives   <= FULL;
        end else if (new_game) begin
            state   <= RESPAWN;
            counter <= '0;
            lives   <= FULL;
        end else begin
            case (state)
                ALIVE: begin
                    counter <= '0;
                    if (hit) begin
                        state <= BURST;
                        lives <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    end
                end
                BURST: begin
                    counter <= (counter == BURST_CYCLES - 32'd1) ? '0 : counter + 32'd1;
                    if (counter == BURST_CYCLES - 32'd1)
                        state <= (lives == 2'd0) ? DEAD : RESPAWN;
                end
                RESPAWN: begin
                    counter <= (counter == RESET_CYCLES - 32'd1) ? '0 : counter + 32'd1;
                    if (counter == RESET_CYCLES - 32'd1)
                        state <= INVULN;
                end
                INVULN: begin
                    counter <= (counter == INVULN_CYCLES - 32'd1) ? '0 : counter + 32'd1;
                    if (counter == INVULN_CYCLES - 32'd1)
                        state <= ALIVE;
                end
                DEAD: begin
                    counter <= '0;
                    lives   <= 2'd0;
                end
                default: begin
                    state   <= ALIVE;
                    counter <= '0;
                end
            endcase
        end
    end
    // Moore decode straight from the state and counter registers
    assign burst      = (state == BURST);
    assign tank_reset = (state == RESPAWN);
    assign invuln     = (state == INVULN);
    assign game_over  = (state == DEAD);
    assign blink      = (state == INVULN) ? ~counter[BLINK_BIT] : 1'b1;
endmodule

// File: tb/tb_tank_life_ctrl.sv
// tb_tank_life_ctrl: directed plus random stimulus against a timeline model
module tb_tank_life_ctrl;
    localparam int BC = 8, RC = 4, IC = 16, LV = 2, BB = 2;
    logic       clk = 1'b0;
    logic       reset = 1'b0, hit = 1'b0, new_game = 1'b0;
    logic       burst, tank_reset, invuln, blink, game_over;
    logic [1:0] lives;
    int errors = 0, checks = 0;
    int now = 0, start = 0, kind = 0, lv = LV;

    tank_life_ctrl #(
        .BURST_CYCLES(BC), .RESET_CYCLES(RC), .INVULN_CYCLES(IC),
        .LIVES(LV), .BLINK_BIT(BB)
    ) dut (
        .clk(clk), .reset(reset), .hit(hit), .new_game(new_game),
        .burst(burst), .tank_reset(tank_reset), .invuln(invuln),
        .blink(blink), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // kind: 0 idle since reset, 1 timeline started by a hit, 2 started by new_game
    // returns 0 alive, 1 exploding, 2 respawn pulse, 3 invulnerable, 4 dead
    function automatic int ph(int k, int d, int l);
        if (k == 1) begin
            if (d < BC) return 1;
            if (l == 0) return 4;
            if (d < BC + RC) return 2;
            if (d < BC + RC + IC) return 3;
            return 0;
        end
        if (k == 2) begin
            if (d < RC) return 2;
            if (d < RC + IC) return 3;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at step %0d: observed=%0h expected=%0h", tag, now, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic h, input logic n);
        int p, d, e;
        reset = r; hit = h; new_game = n;
        @(posedge clk);
        p = ph(kind, now - start, lv);
        now++;
        if (!r) begin kind = 0; lv = LV; end
        else if (n) begin kind = 2; start = now; lv = LV; end
        else if (h && p == 0) begin kind = 1; start = now; lv = lv - 1; end
        @(negedge clk);
        d = now - start;
        p = ph(kind, d, lv);
        e = d - ((kind == 1) ? BC + RC : RC);
        chk("burst", 32'(burst), 32'(p == 1));
        chk("tank_reset", 32'(tank_reset), 32'(p == 2));
        chk("invuln", 32'(invuln), 32'(p == 3));
        chk("game_over", 32'(game_over), 32'(p == 4));
        chk("blink", 32'(blink), (p == 3) ? 32'((e % (2 ** (BB + 1))) < 2 ** BB) : 32'd1);
        chk("lives", 32'(lives), 32'(lv));
    endtask

    initial begin
        step(0, 1, 1);
        step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        repeat (35) step(1, 0, 0);
        step(1, 0, 1);
        repeat (25) step(1, 0, 0);
        repeat (40) step(1, 1, 0);
        for (int i = 0; i < 100; i++) step(1, i[0], 0);
        step(1, 0, 1);
        repeat (25) step(1, 0, 0);
        step(1, 1, 1);
        repeat (25) step(1, 0, 0);
        step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        step(0, 1, 0);
        repeat (3) step(1, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
